crc_share_arbiter: RTL and testbench

Shares one CRC engine (the 12-cycle shift controller plus its datapath) between two requesters, e.g. the write-path encoder and the read-path checker. Arbitrates round-robin, sequences the engine's start/busy/valid handshake, and returns the captured CRC to the winner with a one-cycle done pulse. A watchdog timer converts a hung engine into an error response, so neither requester can deadlock.

---
 rtl/crc_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_crc_share_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/crc_share_arbiter.sv
// Round-robin arbiter sharing one CRC engine between two requesters.
// It sequences the engine's start/valid handshake, and a watchdog turns a hung engine into an error response.
module crc_share_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CRC_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [CRC_W-1:0]  result,
  output logic              err,
  output logic              busy,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_data,
  input  logic              eng_busy,
  input  logic              eng_valid,
  input  logic [CRC_W-1:0]  eng_crc
);

  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [CRC_W-1:0]    result_q, result_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                eng_start_q, eng_start_d;
  logic [DATA_W-1:0]   eng_data_q, eng_data_d;

  // Engine busy is kept only as a debug observation point for timeouts.
  logic eng_busy_unused;
  assign eng_busy_unused = eng_busy;

  // State register; last starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_d      = last_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    result_d    = result_q;
    err_d       = err_q;
    eng_start_d = 1'b0;
    eng_data_d  = eng_data_q;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          win_d       = (req == 2'b11) ? ~last_q : req[1];
          gnt_d       = win_d ? 2'b10 : 2'b01;
          eng_data_d  = win_d ? data1 : data0;
          eng_start_d = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
        // A valid strobe wins over a coincident timeout.
        if (eng_valid) begin
          result_d = eng_crc;
          err_d    = 1'b0;
          done_d   = gnt_q;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = gnt_q;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = win_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;

endmodule

// File: tb/tb_crc_share_arbiter.sv
// Directed bench for crc_share_arbiter with a 12-cycle engine model.
module tb_crc_share_arbiter;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CRC_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [DATA_W-1:0] data0, data1;
  logic [1:0]        gnt, done;
  logic [CRC_W-1:0]  result;
  logic              err, busy, eng_start;
  logic [DATA_W-1:0] eng_data;
  logic              eng_busy, eng_valid;
  logic [CRC_W-1:0]  eng_crc;

  // engine model and stray-strobe injection
  int               cnt;
  logic             valid_m, busy_m, hang;
  logic [CRC_W-1:0] crc_m, model_crc, stray_crc;
  logic             stray_v;

  int n_checks = 0;
  int n_errors = 0;

  assign eng_valid = valid_m | stray_v;
  assign eng_crc   = stray_v ? stray_crc : crc_m;
  assign eng_busy  = busy_m;

  always #5 clk = ~clk;

  crc_share_arbiter #(.DATA_W(DATA_W), .CRC_W(CRC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .eng_start(eng_start), .eng_data(eng_data), .eng_busy(eng_busy),
    .eng_valid(eng_valid), .eng_crc(eng_crc)
  );

  // Engine: start seen in cycle N+1, busy N+2..N+13, valid during N+14.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0; valid_m = 1'b0; busy_m = 1'b0; crc_m = '0;
    end else begin
      valid_m = 1'b0;
      if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          busy_m = 1'b0;
          if (!hang) begin
            valid_m = 1'b1;
            crc_m   = model_crc;
          end
        end
      end
      if (eng_start) begin
        cnt = 13; busy_m = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one job starting in the current IDLE cycle N and checks every cycle up to done.
  task automatic do_job(input logic [1:0] rq, input logic [1:0] rq_after, input logic w,
                        input logic hng, input logic [CRC_W-1:0] crc, input logic stray_start,
                        input string tag);
    logic [1:0]        oh;
    logic [DATA_W-1:0] dexp;
    int                lat;
    oh   = w ? 2'b10 : 2'b01;
    dexp = w ? data1 : data0;
    lat  = hng ? 2 + int'(TIMEOUT) : 15;
    req = rq; hang = hng; model_crc = crc;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      stray_v = 1'b0;
      check($sformatf("%s_start_%0d", tag, k), 32'(eng_start), 32'(k == 1));
      check($sformatf("%s_busy_%0d", tag, k), 32'(busy), 32'(k >= 1 && k <= lat));
      check($sformatf("%s_gnt_%0d", tag, k), 32'(gnt), 32'((k >= 1 && k <= lat) ? oh : 2'b00));
      check($sformatf("%s_done_%0d", tag, k), 32'(done), 32'((k == lat) ? oh : 2'b00));
      if (k == 2) check($sformatf("%s_data", tag), 32'(eng_data), 32'(dexp));
      if (k == lat) begin
        check($sformatf("%s_result", tag), 32'(result), 32'(hng ? 4'h0 : crc));
        check($sformatf("%s_err", tag), 32'(err), 32'(hng));
      end
      if (stray_start && k == 1) stray_v = 1'b1;
    end
    @(posedge clk); #1;
    req = rq_after;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
    hang = 1'b0; model_crc = '0; stray_crc = '0; stray_v = 1'b0;

    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'(2'b00));
    check("rst_done", 32'(done), 32'(2'b00));
    check("rst_result", 32'(result), 32'(4'h0));
    check("rst_err", 32'(err), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_start", 32'(eng_start), 32'(1'b0));
    check("rst_data", 32'(eng_data), 32'(8'h00));
    @(posedge clk); #1;
    rst = 1'b0;

    // single job
    data0 = 8'hA5; data1 = 8'h3C;
    do_job(2'b01, 2'b00, 1'b0, 1'b0, 4'h9, 1'b0, "single");

    // contention from reset: 0,1,0,1
    pulse_reset();
    data0 = 8'h11; data1 = 8'h22;
    do_job(2'b11, 2'b11, 1'b0, 1'b0, 4'h1, 1'b0, "rr0");
    do_job(2'b11, 2'b11, 1'b1, 1'b0, 4'h2, 1'b0, "rr1");
    do_job(2'b11, 2'b11, 1'b0, 1'b0, 4'h3, 1'b0, "rr2");
    do_job(2'b11, 2'b00, 1'b1, 1'b0, 4'h4, 1'b0, "rr3");

    // fairness after requester 1 used alone
    do_job(2'b10, 2'b00, 1'b1, 1'b0, 4'h5, 1'b0, "fair1");
    do_job(2'b11, 2'b10, 1'b0, 1'b0, 4'h6, 1'b0, "fair0");
    do_job(2'b10, 2'b00, 1'b1, 1'b0, 4'hE, 1'b0, "fair1b");

    // hung engine then a normal job
    do_job(2'b01, 2'b00, 1'b0, 1'b1, 4'h8, 1'b0, "tmo");
    do_job(2'b01, 2'b00, 1'b0, 1'b0, 4'h7, 1'b0, "post_tmo");

    // stray valid in IDLE
    stray_crc = 4'hF;
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    check("stray_idle_busy", 32'(busy), 32'(1'b0));
    check("stray_idle_start", 32'(eng_start), 32'(1'b0));
    @(negedge clk);
    check("stray_idle_busy2", 32'(busy), 32'(1'b0));
    check("stray_idle_done", 32'(done), 32'(2'b00));
    check("stray_idle_result", 32'(result), 32'(4'h7));
    @(posedge clk); #1;
    // stray valid in START
    do_job(2'b01, 2'b00, 1'b0, 1'b0, 4'h2, 1'b1, "stray_start");

    // reset in the middle of WAIT
    data1 = 8'h5A; req = 2'b10; hang = 1'b0; model_crc = 4'hC;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("mid_busy_%0d", k), 32'(busy), 32'(k >= 1));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'(2'b00));
    check("mid_rst_busy", 32'(busy), 32'(1'b0));
    check("mid_rst_result", 32'(result), 32'(4'h0));
    check("mid_rst_data", 32'(eng_data), 32'(8'h00));
    check("mid_rst_done", 32'(done), 32'(2'b00));
    req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mid_hold_done_%0d", k), 32'(done), 32'(2'b00));
      check($sformatf("mid_hold_busy_%0d", k), 32'(busy), 32'(1'b0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_job(2'b10, 2'b00, 1'b1, 1'b0, 4'hB, 1'b0, "after_rst");

    repeat (3) @(negedge clk);
    check("end_busy", 32'(busy), 32'(1'b0));
    check("end_done", 32'(done), 32'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
